// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the core and the M-extension unit.
// The core drives start/op/operands; the unit answers with busy/done/result.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [3:0]      alu_ctrl;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, alu_ctrl, operand_a, operand_b,
        input  busy, done, result
    );

    modport slave (
        input  start, alu_ctrl, operand_a, operand_b,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32 shift steps, one fix-up cycle,
// one done cycle. A single 64-bit accumulator serves both MUL and DIV/REM.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);
    localparam logic [3:0] OP_MUL  = 4'b1010;
    localparam logic [3:0] OP_DIV  = 4'b1011;
    localparam logic [3:0] OP_DIVU = 4'b1100;
    localparam logic [3:0] OP_REM  = 4'b1101;
    localparam logic [3:0] OP_REMU = 4'b1110;
    localparam int         CW      = $clog2(XLEN);

    localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CW-1:0]   LAST = {CW{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   result_q, result_d;

    function automatic logic [XLEN-1:0] mag(
        input logic [XLEN-1:0] v,
        input logic            sgn
    );
        return (sgn && v[XLEN-1]) ? -v : v;
    endfunction

    function automatic logic op_valid(input logic [3:0] op);
        return (op >= OP_MUL) && (op <= OP_REMU);
    endfunction

    logic            signed_op;
    logic            in_signed;
    logic [XLEN-1:0] b_mag;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   rem_sh;
    logic [XLEN-1:0] rem_sub;
    logic            can_sub;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;
    logic            b_zero;
    logic            ovf;
    logic [XLEN-1:0] fix_val;

    // Per-step datapath for the shift-add multiply and restoring divide.
    always_comb begin
        signed_op = (op_q == OP_DIV) || (op_q == OP_REM);
        in_signed = (bus.alu_ctrl == OP_DIV) || (bus.alu_ctrl == OP_REM);
        b_mag     = mag(b_q, signed_op);
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]}
                  + (acc_q[0] ? {1'b0, a_q} : '0);
        rem_sh    = acc_q[2*XLEN-1:XLEN-1];
        can_sub   = rem_sh >= {1'b0, b_mag};
        rem_sub   = acc_q[2*XLEN-2:XLEN-1] - b_mag;
        quo       = acc_q[XLEN-1:0];
        rem       = acc_q[2*XLEN-1:XLEN];
        b_zero    = (b_q == '0);
        ovf       = (a_q == MINV) && (b_q == ONES);
    end

    // Sign correction and RISC-V special cases applied in FIX.
    always_comb begin
        fix_val = quo;
        unique case (1'b1)
            op_q == OP_MUL:  fix_val = quo;
            op_q == OP_DIVU: fix_val = b_zero ? ONES : quo;
            op_q == OP_REMU: fix_val = b_zero ? a_q : rem;
            op_q == OP_DIV: begin
                if (b_zero)
                    fix_val = ONES;
                else if (ovf)
                    fix_val = MINV;
                else
                    fix_val = (a_q[XLEN-1] ^ b_q[XLEN-1]) ? -quo : quo;
            end
            op_q == OP_REM: begin
                if (b_zero)
                    fix_val = a_q;
                else if (ovf)
                    fix_val = '0;
                else
                    fix_val = a_q[XLEN-1] ? -rem : rem;
            end
            default: fix_val = quo;
        endcase
    end

    // Next-state logic: accept, iterate, fix up, report.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (bus.start && op_valid(bus.alu_ctrl)) begin
                    op_d    = bus.alu_ctrl;
                    a_d     = bus.operand_a;
                    b_d     = bus.operand_b;
                    cnt_d   = '0;
                    state_d = CALC;
                    if (bus.alu_ctrl == OP_MUL)
                        acc_d = {{XLEN{1'b0}}, bus.operand_b};
                    else
                        acc_d = {{XLEN{1'b0}},
                                 mag(bus.operand_a, in_signed)};
                end
            end
            CALC: begin
                if (op_q == OP_MUL)
                    acc_d = {mul_sum, acc_q[XLEN-1:1]};
                else if (can_sub)
                    acc_d = {rem_sub, acc_q[XLEN-2:0], 1'b1};
                else
                    acc_d = {acc_q[2*XLEN-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST)
                    state_d = FIX;
            end
            FIX: begin
                result_d = fix_val;
                state_d  = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset that also aborts a running op.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    // Handshake outputs decoded from state.
    always_comb begin
        bus.busy   = (state_q != IDLE);
        bus.done   = (state_q == DONE);
        bus.result = result_q;
    end
endmodule
